// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP-to-linear decoder.
// Word layout: [7] sign, [6:4] exponent, [3:0] significand.
package fp_pkg;

    localparam int unsigned FP_W  = 8;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;
    localparam int unsigned LIN_W = 12;
    localparam int unsigned MAG_W = 11;

    // Bit-field positions inside the FP word
    localparam int unsigned SIGN_BIT = 7;
    localparam int unsigned EXP_MSB  = 6;
    localparam int unsigned EXP_LSB  = 4;
    localparam int unsigned SIG_MSB  = 3;
    localparam int unsigned SIG_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_to_linear_decoder.sv
// Expands an 8-bit FP word (S, E, F) into a 12-bit two's-complement value
// V = (-1)^S * (F << E), shifting one bit per cycle with valid/ready on both
// sides. Optional build macro FP_DECODE_MIDPOINT_EN adds 2^(E-1) for E != 0
// (midpoint of the encoder's truncation interval) by shifting a 1 into the
// LSB on the first SHIFT cycle.
module fp_to_linear_decoder
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  fp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LIN_W-1:0] linear_out,
    output logic             busy
);

    localparam logic [EXP_W-1:0] CNT_LAST = EXP_W'(1);
    localparam logic [LIN_W-1:0] LIN_ONE  = LIN_W'(1);

    state_e             state_q;
    logic               sign_q;
    logic [MAG_W-1:0]   mag_q;
    logic [EXP_W-1:0]   cnt_q;
    logic               shift_in;
    logic [LIN_W-1:0]   mag_ext;
    logic [LIN_W-1:0]   signed_val;

`ifdef FP_DECODE_MIDPOINT_EN
    logic               first_q;
    assign shift_in = first_q;
`else
    assign shift_in = 1'b0;
`endif

    // Handshake/status outputs decoded from state; ready is held low while in reset
    always_comb begin
        in_ready = (state_q == IDLE) && rst_n;
        busy     = (state_q != IDLE);
    end

    // Sign application for the SIGN state (negative zero naturally yields zero)
    always_comb begin
        mag_ext    = {1'b0, mag_q};
        signed_val = sign_q ? (~mag_ext + LIN_ONE) : mag_ext;
    end

    // Control FSM with datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            linear_out <= '0;
`ifdef FP_DECODE_MIDPOINT_EN
            first_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q  <= fp_in[SIGN_BIT];
                        mag_q   <= {{(MAG_W-SIG_W){1'b0}}, fp_in[SIG_MSB:SIG_LSB]};
                        cnt_q   <= fp_in[EXP_MSB:EXP_LSB];
`ifdef FP_DECODE_MIDPOINT_EN
                        first_q <= 1'b1;
`endif
                        state_q <= (fp_in[EXP_MSB:EXP_LSB] != '0) ? SHIFT : SIGN;
                    end
                end
                SHIFT: begin
                    mag_q <= {mag_q[MAG_W-2:0], shift_in};
                    cnt_q <= cnt_q - CNT_LAST;
`ifdef FP_DECODE_MIDPOINT_EN
                    first_q <= 1'b0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    linear_out <= signed_val;
                    out_valid  <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_linear_decoder.sv
// Self-checking bench for fp_to_linear_decoder. Expected values come from a
// behavioural model of V = (-1)^S * (F << E) (+ 2^(E-1) when built with
// FP_DECODE_MIDPOINT_EN) and are queued when a word is driven.
module tb_fp_to_linear_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] linear_out;
    logic        busy;

    int assertions = 0;
    int failures   = 0;
    logic [11:0] exp_q[$];

    fp_to_linear_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fp_in      (fp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .linear_out (linear_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [7:0] w);
        int e;
        int m;
        e = int'(w[6:4]);
        m = int'(w[3:0]) << e;
`ifdef FP_DECODE_MIDPOINT_EN
        if (e != 0) m = m + (1 << (e - 1));
`endif
        if (w[7]) m = -m;
        return 12'(m);
    endfunction

    function automatic logic [11:0] pop_exp();
        if (exp_q.size() == 0) return 12'hxxx;
        return exp_q.pop_front();
    endfunction

    // Waits (bounded) for in_ready, presents one word for one accepting edge.
    task automatic drive_word(input logic [7:0] w);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            assertions++; failures++;
            $display("FAIL drive_word_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        fp_in    = w;
        exp_q.push_back(model(w));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; fp_in = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (in_ready !== 1'b0) begin failures++;
            $display("FAIL reset_in_ready_low: got %b, required 0", in_ready); end
        assertions++;
        if (out_valid !== 1'b0 || linear_out !== 12'h000 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_outputs: out_valid=%b linear_out=%h busy=%b, required 0 000 0",
                     out_valid, linear_out, busy); end
        rst_n = 1'b1;
        #1;
        assertions++;
        if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready_after: got %b, required 1", in_ready); end
    endtask

    // Decodes one word with out_ready high, checking latency, data and return to IDLE.
    task automatic test_word(input string name, input logic [7:0] w);
        int lat;
        logic [11:0] exp;
        drive_word(w);
        wait_out(lat);
        exp = pop_exp();
        assertions++;
        if (lat != int'(w[6:4]) + 1) begin failures++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, int'(w[6:4]) + 1); end
        assertions++;
        if (linear_out !== exp) begin failures++;
            $display("FAIL %s_value: got %h, required %h", name, linear_out, exp); end
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL %s_idle: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     name, out_valid, busy, in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] exp;
        out_ready = 1'b0;
        drive_word(8'b0_010_0110);
        wait_out(lat);
        exp = pop_exp();
        assertions++;
        if (out_valid !== 1'b1) begin failures++;
            $display("FAIL bp_valid_rise: out_valid=%b, required 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            fp_in    = 8'(8'h11 * (i + 1));
            @(posedge clk); #1;
            assertions++;
            if (out_valid !== 1'b1 || linear_out !== exp || in_ready !== 1'b0 || busy !== 1'b1)
            begin failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b linear_out=%h in_ready=%b busy=%b, required 1 %h 0 1",
                         i, out_valid, linear_out, in_ready, busy, exp); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        assertions++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || linear_out !== exp)
        begin failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b linear_out=%h, required 0 1 0 %h",
                     out_valid, in_ready, busy, linear_out, exp); end
        test_word("bp_next", 8'b1_001_0111);
    endtask

    task automatic test_reset_mid();
        drive_word(8'b0_110_0011);
        // Now in the first SHIFT cycle; move to the third.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        void'(pop_exp());
        assertions++;
        if (out_valid !== 1'b0 || linear_out !== 12'h000 || busy !== 1'b0 || in_ready !== 1'b1)
        begin failures++;
            $display("FAIL reset_mid: out_valid=%b linear_out=%h busy=%b in_ready=%b, required 0 000 0 1",
                     out_valid, linear_out, busy, in_ready); end
        test_word("after_reset", 8'b0_100_1001);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            test_word($sformatf("b2b_%0d", i), w);
        end
    endtask

    initial begin
        test_reset();
        test_word("zero_exp", 8'b0_000_0101);
        test_word("max", 8'b0_111_1111);
        test_word("negative", 8'b1_011_1010);
        test_word("neg_zero", 8'b1_101_0000);
        test_word("neg_zero_e0", 8'b1_000_0000);
        test_word("neg_e0", 8'b1_000_1111);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
